game_flow_controller: RTL and testbench
=======================================

Name: game_flow_controller

Overview:
Parametrised top-level game-flow FSM for the pinball design. It sequences title screen, play, pause, ball respawn, game over and win. It tracks lives and level, and drives screen selection, the physics run-enable and new-ball requests. It sits between the key and collision logic and the drawing and physics blocks, and generalises the single start-screen controller.

Parameters:
NUM_LIVES, 3, balls per game (1..15)
NUM_LEVELS, 4, levels to clear before WIN (1..16)
RESPAWN_CYCLES, 25_000_000, cycles held in RESPAWN before play resumes (>=1)
GAMEOVER_CYCLES, 50_000_000, minimum cycles in GAME_OVER/WIN before key0 is accepted (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
key0IsPressed  in  1  start/restart key, level signal
key1IsPressed  in  1  pause/resume key, level signal
ballLost  in  1  one-cycle pulse: ball left the table
levelCleared  in  1  one-cycle pulse: all level targets hit
screenSel  out  3  current screen, game_flow_pkg::screen_t encoding
start  out  1  game screen active (PLAY, PAUSED, RESPAWN)
run  out  1  physics enable (PLAY only)
newBall  out  1  one-cycle pulse: spawn ball at launcher
livesLeft  out  4  remaining balls
level  out  4  current level, 0-based

Behaviour:
- Reset: state=TITLE, livesLeft=NUM_LIVES, level=0, hold counter=0, newBall=0. Both key-history registers reset to 1, so a key held through reset gives no edge.
- Key edges: rise0 = key0IsPressed & ~prev0; rise1 likewise. Only rising edges act. A held key never repeats.
- Moore outputs are decoded from the registered state:
  - screenSel = state
  - start = 1 in PLAY/PAUSED/RESPAWN
  - run = 1 only in PLAY
- newBall is registered. It is 1 in the first PLAY cycle after entry from TITLE or RESPAWN, never after PAUSED.
- States and transitions (evaluated each clk; at most one transition per cycle):
  - TITLE: rise0 -> PLAY. Loads livesLeft=NUM_LIVES and level=0.
  - PLAY, priority order:
    - levelCleared: if level==NUM_LEVELS-1 -> WIN, else level+1 and -> RESPAWN.
    - ballLost: livesLeft-1. If the old livesLeft==1 -> GAME_OVER (livesLeft=0), else -> RESPAWN.
    - rise1 -> PAUSED.
  - PAUSED: rise1 -> PLAY. ballLost, levelCleared and rise0 are ignored.
  - RESPAWN: counter cleared on entry, increments each cycle. When counter==RESPAWN_CYCLES-1 -> PLAY, so the state lasts exactly RESPAWN_CYCLES cycles. Events are ignored.
  - GAME_OVER / WIN: counter cleared on entry and saturates at GAMEOVER_CYCLES-1. rise0 -> TITLE only if the counter has saturated; earlier edges are discarded, not queued.
- Simultaneous events in PLAY:
  - levelCleared + ballLost: the level-clear wins and the life is kept.
  - ballLost + rise1: the loss wins and the pause is dropped.
- Arithmetic: livesLeft and level never wrap. livesLeft stops at 0 and level stops at NUM_LEVELS-1.
- Counter width is $clog2(max(RESPAWN_CYCLES,GAMEOVER_CYCLES)+1).
- reset during any state returns to reset values on the next clk edge. A pending newBall is cancelled.
- Illegal state encodings (6, 7) -> TITLE on the next clk.

Decomposition:
- game_flow_pkg holds:
  - screen_t: 3-bit enum, TITLE=0, PLAY=1, PAUSED=2, RESPAWN=3, GAME_OVER=4, WIN=5.
  - SCREEN_W=3.
- One sub-module: key_edge_detect (1-bit rising-edge detector, history register resets to 1). It is instantiated twice.
- Hold counter and FSM live in game_flow_controller.

Test Plan:
Params for all scenarios: NUM_LIVES=2, NUM_LEVELS=2, RESPAWN_CYCLES=4, GAMEOVER_CYCLES=8.
1. key0 held high through and after reset release -> stays TITLE. Release, then press -> PLAY next clk; newBall=1 for exactly 1 cycle; livesLeft=2, level=0, run=1.
2. In PLAY pulse ballLost -> RESPAWN, livesLeft=1, run=0, start=1. Exactly 4 cycles later -> PLAY with newBall pulse. Second ballLost -> GAME_OVER, livesLeft=0.
3. In GAME_OVER press key0 at cycle 3 -> ignored. Press again after cycle 8 -> TITLE. Next key0 -> PLAY with livesLeft=2, level=0.
4. In PLAY: levelCleared -> RESPAWN, level=1. Back in PLAY, levelCleared -> WIN, screenSel=5, level stays 1.
5. In PLAY press key1 -> PAUSED, run=0. Pulse ballLost and levelCleared while PAUSED -> no change. Press key1 -> PLAY, no newBall.
6. Same cycle levelCleared+ballLost at livesLeft=1 -> RESPAWN, livesLeft=1, level+1. Same cycle ballLost+key1 rise -> RESPAWN, not PAUSED. Assert reset mid-RESPAWN -> TITLE next clk, no newBall.

Source files
------------

// File: rtl/game_flow_pkg.sv
// Shared screen encoding for the pinball game-flow controller.
// Pure definitions: no latency, no flow control.
package game_flow_pkg;

    localparam int SCREEN_W = 3;

    typedef enum logic [SCREEN_W-1:0] {
        TITLE     = 3'd0,
        PLAY      = 3'd1,
        PAUSED    = 3'd2,
        RESPAWN   = 3'd3,
        GAME_OVER = 3'd4,
        WIN       = 3'd5
    } screen_t;

endpackage

// File: rtl/game_flow_controller_if.sv
// Key/collision inputs and screen/physics outputs of the game-flow controller.
// Wires only: no latency, no flow control.
interface game_flow_controller_if;
    import game_flow_pkg::*;

    logic                key0IsPressed;
    logic                key1IsPressed;
    logic                ballLost;
    logic                levelCleared;
    logic [SCREEN_W-1:0] screenSel;
    logic                start;
    logic                run;
    logic                newBall;
    logic [3:0]          livesLeft;
    logic [3:0]          level;

    modport master (
        output key0IsPressed, key1IsPressed, ballLost, levelCleared,
        input  screenSel, start, run, newBall, livesLeft, level
    );

    modport slave (
        input  key0IsPressed, key1IsPressed, ballLost, levelCleared,
        output screenSel, start, run, newBall, livesLeft, level
    );

endinterface

// File: rtl/game_flow_controller_key_edge_detect.sv
// Rising-edge detector for a level key; history resets high so a key held through reset is ignored.
// Combinational edge output from a one-cycle history register; no flow control.
module key_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = key;
        rise   = key & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) prev_q <= 1'b1;
        else       prev_q <= prev_d;
    end

endmodule

// File: rtl/game_flow_controller.sv
// Game-flow FSM: title, play, pause, respawn, game over and win; tracks lives and level.
// Outputs are registered-state decodes (newBall is a registered pulse); inputs are never stalled.
module game_flow_controller
    import game_flow_pkg::*;
#(
    parameter int NUM_LIVES       = 3,
    parameter int NUM_LEVELS      = 4,
    parameter int RESPAWN_CYCLES  = 25_000_000,
    parameter int GAMEOVER_CYCLES = 50_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    game_flow_controller_if.slave  bus
);

    localparam int HOLD_MAX = (RESPAWN_CYCLES > GAMEOVER_CYCLES) ? RESPAWN_CYCLES : GAMEOVER_CYCLES;
    localparam int CNT_W    = $clog2(HOLD_MAX + 1);

    localparam logic [CNT_W-1:0] RESPAWN_LAST = CNT_W'(RESPAWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(GAMEOVER_CYCLES - 1);
    localparam logic [3:0]       LIVES_INIT   = 4'(NUM_LIVES);
    localparam logic [3:0]       LEVEL_LAST   = 4'(NUM_LEVELS - 1);

    screen_t          state_q, state_d;
    logic [3:0]       lives_q, lives_d;
    logic [3:0]       level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             new_ball_q, new_ball_d;
    logic             rise0, rise1;

    key_edge_detect u_key0 (.clk(clk), .reset(reset), .key(bus.key0IsPressed), .rise(rise0));
    key_edge_detect u_key1 (.clk(clk), .reset(reset), .key(bus.key1IsPressed), .rise(rise1));

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        level_d    = level_q;
        cnt_d      = cnt_q;
        new_ball_d = 1'b0;

        case (state_q)
            TITLE: begin
                if (rise0) begin
                    state_d    = PLAY;
                    lives_d    = LIVES_INIT;
                    level_d    = '0;
                    new_ball_d = 1'b1;
                end
            end
            PLAY: begin
                // Level clear outranks a simultaneous loss, which outranks a pause.
                if (bus.levelCleared) begin
                    cnt_d = '0;
                    if (level_q >= LEVEL_LAST) begin
                        state_d = WIN;
                    end else begin
                        level_d = level_q + 4'd1;
                        state_d = RESPAWN;
                    end
                end else if (bus.ballLost) begin
                    cnt_d = '0;
                    if (lives_q <= 4'd1) begin
                        lives_d = '0;
                        state_d = GAME_OVER;
                    end else begin
                        lives_d = lives_q - 4'd1;
                        state_d = RESPAWN;
                    end
                end else if (rise1) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (rise1) state_d = PLAY;
            end
            RESPAWN: begin
                if (cnt_q == RESPAWN_LAST) begin
                    state_d    = PLAY;
                    new_ball_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAME_OVER, WIN: begin
                // Restart edges before the hold expires are dropped, not remembered.
                if (cnt_q != HOLD_LAST) cnt_d = cnt_q + CNT_W'(1);
                else if (rise0)         state_d = TITLE;
            end
            default: begin
                state_d = TITLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= TITLE;
            lives_q    <= LIVES_INIT;
            level_q    <= '0;
            cnt_q      <= '0;
            new_ball_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            new_ball_q <= new_ball_d;
        end
    end

    always_comb begin
        bus.screenSel = state_q;
        bus.start     = (state_q == PLAY) || (state_q == PAUSED) || (state_q == RESPAWN);
        bus.run       = (state_q == PLAY);
        bus.newBall   = new_ball_q;
        bus.livesLeft = lives_q;
        bus.level     = level_q;
    end

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with NUM_LIVES=2, NUM_LEVELS=2, RESPAWN=4, GAMEOVER=8.
module tb_game_flow_controller;

    logic clk = 1'b0;
    logic reset = 1'b1;

    game_flow_controller_if bus ();

    game_flow_controller #(
        .NUM_LIVES      (2),
        .NUM_LEVELS     (2),
        .RESPAWN_CYCLES (4),
        .GAMEOVER_CYCLES(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [13:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    localparam logic [2:0] S_TITLE = 3'd0, S_PLAY = 3'd1, S_PAUSED = 3'd2,
                           S_RESP  = 3'd3, S_GO   = 3'd4, S_WIN    = 3'd5;

    // Queue the expected post-edge outputs, clock once, then compare.
    task automatic step(input string tag, input logic [2:0] scr, input logic nb,
                        input logic [3:0] lives, input logic [3:0] lvl);
        exp_t e;
        exp_t got;
        logic st, rn;
        logic [13:0] obs;
        st = (scr == S_PLAY) || (scr == S_PAUSED) || (scr == S_RESP);
        rn = (scr == S_PLAY);
        e.tag = tag;
        e.v   = {scr, st, rn, nb, lives, lvl};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        obs = {bus.screenSel, bus.start, bus.run, bus.newBall, bus.livesLeft, bus.level};
        tests++;
        assert (obs === got.v)
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", got.tag, obs, got.v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.key0IsPressed = 1'b1;
        bus.key1IsPressed = 1'b0;
        bus.ballLost      = 1'b0;
        bus.levelCleared  = 1'b0;

        // 1: key0 held through reset gives no edge
        step("reset", S_TITLE, 0, 2, 0);
        reset = 1'b0;
        step("held_key0_a", S_TITLE, 0, 2, 0);
        step("held_key0_b", S_TITLE, 0, 2, 0);
        bus.key0IsPressed = 1'b0;
        step("key0_release", S_TITLE, 0, 2, 0);
        bus.key0IsPressed = 1'b1;
        step("start_play", S_PLAY, 1, 2, 0);
        bus.key0IsPressed = 1'b0;
        step("newball_once", S_PLAY, 0, 2, 0);

        // 2: lose a ball, respawn lasts exactly 4 cycles, then game over
        bus.ballLost = 1'b1;
        step("lost_to_respawn", S_RESP, 0, 1, 0);
        bus.ballLost = 1'b0;
        for (int i = 0; i < 3; i++) step("respawn_hold", S_RESP, 0, 1, 0);
        step("respawn_exit", S_PLAY, 1, 1, 0);
        step("respawn_nb_clear", S_PLAY, 0, 1, 0);
        bus.ballLost = 1'b1;
        step("game_over", S_GO, 0, 0, 0);
        bus.ballLost = 1'b0;

        // 3: early restart discarded, later one accepted
        step("go_cnt1", S_GO, 0, 0, 0);
        step("go_cnt2", S_GO, 0, 0, 0);
        bus.key0IsPressed = 1'b1;
        step("go_early_key0", S_GO, 0, 0, 0);
        bus.key0IsPressed = 1'b0;
        for (int i = 0; i < 5; i++) step("go_no_queue", S_GO, 0, 0, 0);
        bus.key0IsPressed = 1'b1;
        step("go_to_title", S_TITLE, 0, 0, 0);
        bus.key0IsPressed = 1'b0;
        step("title_idle", S_TITLE, 0, 0, 0);
        bus.key0IsPressed = 1'b1;
        step("restart_play", S_PLAY, 1, 2, 0);
        bus.key0IsPressed = 1'b0;

        // 4: clear both levels, level saturates at WIN
        bus.levelCleared = 1'b1;
        step("clear_lvl0", S_RESP, 0, 2, 1);
        bus.levelCleared = 1'b0;
        for (int i = 0; i < 3; i++) step("clear_respawn", S_RESP, 0, 2, 1);
        step("lvl1_play", S_PLAY, 1, 2, 1);
        bus.levelCleared = 1'b1;
        step("win", S_WIN, 0, 2, 1);
        bus.levelCleared = 1'b0;
        for (int i = 0; i < 7; i++) step("win_hold", S_WIN, 0, 2, 1);
        bus.key0IsPressed = 1'b1;
        step("win_to_title", S_TITLE, 0, 2, 1);
        bus.key0IsPressed = 1'b0;
        step("title_idle2", S_TITLE, 0, 2, 1);
        bus.key0IsPressed = 1'b1;
        step("play_again", S_PLAY, 1, 2, 0);
        bus.key0IsPressed = 1'b0;

        // 5: pause ignores events; resume gives no newBall
        bus.key1IsPressed = 1'b1;
        step("pause", S_PAUSED, 0, 2, 0);
        step("pause_held_key1", S_PAUSED, 0, 2, 0);
        bus.key1IsPressed = 1'b0;
        bus.ballLost = 1'b1;
        bus.levelCleared = 1'b1;
        step("pause_ignores_events", S_PAUSED, 0, 2, 0);
        bus.ballLost = 1'b0;
        bus.levelCleared = 1'b0;
        bus.key0IsPressed = 1'b1;
        step("pause_ignores_key0", S_PAUSED, 0, 2, 0);
        bus.key0IsPressed = 1'b0;
        bus.key1IsPressed = 1'b1;
        step("resume", S_PLAY, 0, 2, 0);
        bus.key1IsPressed = 1'b0;
        step("resume_no_nb", S_PLAY, 0, 2, 0);

        // 6: simultaneous events and reset mid-respawn
        bus.ballLost = 1'b1;
        bus.key1IsPressed = 1'b1;
        step("lost_beats_pause", S_RESP, 0, 1, 0);
        bus.ballLost = 1'b0;
        bus.key1IsPressed = 1'b0;
        for (int i = 0; i < 3; i++) step("sim_respawn", S_RESP, 0, 1, 0);
        step("sim_play", S_PLAY, 1, 1, 0);
        bus.ballLost = 1'b1;
        bus.levelCleared = 1'b1;
        step("clear_beats_lost", S_RESP, 0, 1, 1);
        bus.ballLost = 1'b0;
        bus.levelCleared = 1'b0;
        step("resp_cnt1", S_RESP, 0, 1, 1);
        step("resp_cnt2", S_RESP, 0, 1, 1);
        step("resp_cnt3", S_RESP, 0, 1, 1);
        reset = 1'b1;
        step("reset_mid_respawn", S_TITLE, 0, 2, 0);
        reset = 1'b0;
        step("after_reset", S_TITLE, 0, 2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
